// File: rtl/register_file_multiport.sv
// Multiport register file: NUM_READ registered read ports, one write port, combinational debug port.
// Storage has no reset; a post-reset sweep FSM writes every register before normal access is allowed.
module register_file_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int INIT_MODE  = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
  input  logic [NUM_READ-1:0]            read_enable,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]          write_data_in,
  input  logic [ADDR_WIDTH-1:0]          read_address_debug,
  output logic [DATA_WIDTH-1:0]          data_out_debug,
  output logic                           init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Write-first: a same-cycle write to the read address is forwarded.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] a);
    if (is_zero(a))
      return '0;
    if (write_enable && (write_address == a))
      return write_data_in;
    return mem[a];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_wa    = write_address;
    mem_wd    = write_data_in;
    case (state)
      INIT: begin
        mem_we  = reset_n;
        mem_wa  = cnt;
        mem_wd  = (INIT_MODE != 0) ? DATA_WIDTH'(cnt) : '0;
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == ADDR_WIDTH'(DEPTH - 1))
          state_nxt = RUN;
      end
      RUN: begin
        mem_we = reset_n && write_enable && !is_zero(write_address);
      end
    endcase
  end

  assign init_busy = (state == INIT);

  // Storage stage: plain synchronous write, no reset, so it can map to RAM.
  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  // Read stage: one register per port, held while its enable is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < NUM_READ; k++) begin
        if (read_enable[k])
          data_out[k*DATA_WIDTH +: DATA_WIDTH] <= read_value(read_address[k*ADDR_WIDTH +: ADDR_WIDTH]);
      end
    end
  end

  assign data_out_debug = is_zero(read_address_debug) ? '0 : mem[read_address_debug];

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport: two instances (zero-reg/index-init and plain/zero-init)
// driven identically and compared each cycle against an array-based reference model.
module tb_register_file_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
  localparam int RAW   = NR * AW;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [RAW-1:0] ra;
  logic [NR-1:0]  re;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic [AW-1:0]  dbg;
  logic [NR*DW-1:0] dout_a, dout_b;
  logic [DW-1:0]  dbg_a, dbg_b;
  logic           busy_a, busy_b;

  always #5 clock = ~clock;

  register_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .INIT_MODE(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .read_address(ra), .read_enable(re), .data_out(dout_a),
    .write_enable(we), .write_address(wa), .write_data_in(wd), .read_address_debug(dbg),
    .data_out_debug(dbg_a), .init_busy(busy_a));

  register_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0), .INIT_MODE(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .read_address(ra), .read_enable(re), .data_out(dout_b),
    .write_enable(we), .write_address(wa), .write_data_in(wd), .read_address_debug(dbg),
    .data_out_debug(dbg_b), .init_busy(busy_b));

  // Reference model: index 0 = zero-reg/index-init instance, index 1 = ordinary/zero-init instance.
  logic [DW-1:0] mdl_mem [2][DEPTH];
  logic [DW-1:0] mdl_out [2][NR];
  bit            known   [DEPTH];
  logic          mdl_busy;
  int            swept;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] ref_read(input int i, input logic [AW-1:0] a);
    if (i == 0 && a == 0) return '0;
    if (we && wa == a) return wd;
    return mdl_mem[i][a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NR; k++)
        mdl_out[i][k] = '0;
    mdl_busy = 1'b1;
    swept    = 0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] rd [2][NR];
    if (mdl_busy) begin
      for (int i = 0; i < 2; i++)
        mdl_mem[i][swept] = (i == 0) ? DW'(swept) : '0;
      known[swept] = 1'b1;
      swept++;
      if (swept == DEPTH) mdl_busy = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < NR; k++)
          rd[i][k] = re[k] ? ref_read(i, ra[k*AW +: AW]) : mdl_out[i][k];
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NR; k++) mdl_out[i][k] = rd[i][k];
        if (we && !(i == 0 && wa == 0)) mdl_mem[i][wa] = wd;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [NR*DW-1:0] d;
      logic [DW-1:0]    g;
      d = (i == 0) ? dout_a : dout_b;
      g = (i == 0) ? dbg_a : dbg_b;
      chk($sformatf("busy%0d", i), DW'((i == 0) ? busy_a : busy_b), DW'(mdl_busy));
      for (int k = 0; k < NR; k++)
        chk($sformatf("out%0d_p%0d", i, k), d[k*DW +: DW], mdl_out[i][k]);
      if (i == 0 && dbg == 0)
        chk("dbg0_zero", g, '0);
      else if (known[dbg])
        chk($sformatf("dbg%0d_a%0d", i, dbg), g, mdl_mem[i][dbg]);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic rand_inputs(input bit force_we);
    ra  = RAW'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      ra[AW-1:0]  = AW'($urandom_range(0, 7));
      ra[2*AW-1:AW] = AW'($urandom_range(0, 7));
    end
    re  = NR'($urandom);
    we  = force_we ? 1'b1 : 1'($urandom);
    wa  = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) wa = AW'($urandom);
    wd  = $urandom;
    dbg = AW'($urandom);
  endtask

  task automatic idle();
    re = '0; we = 1'b0; wa = '0; wd = '0; ra = '0;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
    idle();
    dbg     = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    #1 check_outputs();

    // Initial sweep with writes and reads hammered; none of them may land.
    for (int c = 0; c < DEPTH; c++) begin
      rand_inputs(1'b1);
      cyc();
    end
    idle();
    dbg = 5'd7;  #1 chk("dbg7_idx", dbg_a, 32'd7); chk("dbg7_zero", dbg_b, 32'd0);
    dbg = 5'd0;  #1 chk("dbg0_idx", dbg_a, 32'd0);

    // Write then read one cycle later.
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    cyc();
    we = 1'b0; re = 2'b01; ra = {5'd0, 5'd5};
    cyc();
    chk("wr_rd_5", dout_a[31:0], 32'hDEAD_BEEF);

    // Same-cycle write and dual read of one address.
    we = 1'b1; wa = 5'd9; wd = 32'h0000_1234; re = 2'b11; ra = {5'd9, 5'd9}; dbg = 5'd9;
    #1 chk("bypass_dbg_pre", dbg_a, 32'd9);
    cyc();
    chk("bypass_p0", dout_a[31:0], 32'h1234);
    chk("bypass_p1", dout_a[63:32], 32'h1234);
    chk("bypass_dbg_post", dbg_a, 32'h1234);

    // Register 0 write: dropped only on the zero-reg instance.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; re = 2'b00;
    cyc();
    we = 1'b0; re = 2'b01; ra = {5'd0, 5'd0}; dbg = 5'd0;
    cyc();
    chk("zr_read", dout_a[31:0], 32'd0);
    chk("nz_read", dout_b[31:0], 32'hFFFF_FFFF);
    chk("zr_dbg", dbg_a, 32'd0);
    chk("nz_dbg", dbg_b, 32'hFFFF_FFFF);

    // Read-enable hold on port 1 while its address moves.
    re = 2'b11; ra = {5'd3, 5'd5};
    cyc();
    re = 2'b01; ra = {5'd7, 5'd9};
    cyc();
    chk("hold_p1", dout_a[63:32], 32'd3);
    chk("upd_p0", dout_a[31:0], 32'h1234);

    for (int c = 0; c < 400; c++) begin
      rand_inputs(1'b0);
      cyc();
    end

    // Async clear of live outputs mid-cycle.
    idle(); re = 2'b11; ra = {5'd9, 5'd5};
    cyc();
    reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    chk("async_clr", dout_a[31:0] | dout_a[63:32] | dout_b[31:0] | dout_b[63:32], 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1 check_outputs();

    // Reset again at sweep cycle 10; the restarted sweep must run the full length.
    for (int c = 0; c < 10; c++) begin
      rand_inputs(1'b1);
      cyc();
    end
    reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      rand_inputs(1'b1);
      cyc();
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      dbg = AW'(a);
      #1 check_outputs();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
